// File: rtl/turn_signal_seq_if.sv
// Turn-signal sequencer port bundle.
// Requests flow in, lamp drives and status flow out.
interface turn_signal_seq_if #(
  parameter int LAMPS = 3
);
  logic             left;
  logic             right;
  logic             hazard;
  logic [LAMPS-1:0] la;
  logic [LAMPS-1:0] ra;
  logic             tick;
  logic             busy;

  modport master (
    output left, right, hazard,
    input  la, ra, tick, busy
  );

  modport slave (
    input  left, right, hazard,
    output la, ra, tick, busy
  );
endinterface

// File: rtl/turn_signal_seq.sv
// Turn-signal lamp sequencer: prescaled step FSM
// driving fill or chase patterns on left/right lamps.
module turn_signal_seq #(
  parameter int LAMPS = 3,
  parameter int DIV   = 12_500_000,
  parameter int CHASE = 0
) (
  input  logic               clk,
  input  logic               rst,
  turn_signal_seq_if.slave   bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int KW = $clog2(LAMPS + 1);
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
  localparam logic [KW-1:0] KMAX = KW'(LAMPS);
  localparam logic [KW-1:0] KONE = KW'(1);

  typedef enum logic [1:0] {
    IDLE,
    LSEQ,
    RSEQ,
    HAZ
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [KW-1:0]    k_q;
  logic [KW-1:0]    k_d;
  logic [LAMPS-1:0] la_q;
  logic [LAMPS-1:0] ra_q;
  logic [LAMPS-1:0] la_d;
  logic [LAMPS-1:0] ra_d;
  logic [LAMPS-1:0] pat;
  logic [CW-1:0]    cnt;
  logic             tick;
  logic             both;

  assign tick = (cnt == CMAX);
  assign both = bus.hazard | (bus.left & bus.right);

  // free-running prescaler, unaffected by FSM activity
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (both) begin
          state_d = HAZ;
        end else if (bus.left) begin
          state_d = LSEQ;
          k_d     = KONE;
        end else if (bus.right) begin
          state_d = RSEQ;
          k_d     = KONE;
        end
      end
      LSEQ, RSEQ: begin
        if (both) begin
          state_d = HAZ;
          k_d     = KONE;
        end else if (k_q < KMAX) begin
          k_d = k_q + 1'b1;
        end else begin
          state_d = IDLE;
          k_d     = KONE;
        end
      end
      HAZ: begin
        state_d = IDLE;
        k_d     = KONE;
      end
    endcase
  end

  // lamp pattern for the step being entered
  always_comb begin
    pat = '0;
    for (int i = 0; i < LAMPS; i++) begin
      if (CHASE != 0) begin
        pat[i] = (KW'(i + 1) == k_d);
      end else begin
        pat[i] = (KW'(i) < k_d);
      end
    end
  end

  always_comb begin
    la_d = '0;
    ra_d = '0;
    unique case (state_d)
      IDLE: ;
      LSEQ: la_d = pat;
      RSEQ: ra_d = pat;
      HAZ: begin
        la_d = '1;
        ra_d = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= KONE;
      la_q    <= '0;
      ra_q    <= '0;
    end else if (tick) begin
      state_q <= state_d;
      k_q     <= k_d;
      la_q    <= la_d;
      ra_q    <= ra_d;
    end
  end

  assign bus.la   = la_q;
  assign bus.ra   = ra_q;
  assign bus.tick = tick;
  assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_turn_signal_seq.sv
// Scoreboard bench for turn_signal_seq across
// fill, chase, DIV=1 and LAMPS=4 instances.
module tb_turn_signal_seq;

  logic clk;
  logic rst;

  int n_cmp;
  int n_bad;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  logic [15:0] q3[$];
  logic [3:0]  pend;

  turn_signal_seq_if #(.LAMPS(3)) if0 ();
  turn_signal_seq_if #(.LAMPS(3)) if1 ();
  turn_signal_seq_if #(.LAMPS(3)) if2 ();
  turn_signal_seq_if #(.LAMPS(4)) if3 ();

  turn_signal_seq #(.LAMPS(3), .DIV(4), .CHASE(0)) u0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  turn_signal_seq #(.LAMPS(3), .DIV(4), .CHASE(1)) u1 (
    .clk(clk), .rst(rst), .bus(if1)
  );
  turn_signal_seq #(.LAMPS(3), .DIV(1), .CHASE(0)) u2 (
    .clk(clk), .rst(rst), .bus(if2)
  );
  turn_signal_seq #(.LAMPS(4), .DIV(4), .CHASE(0)) u3 (
    .clk(clk), .rst(rst), .bus(if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] l,
                      input logic [7:0] r);
    case (i)
      0: q0.push_back({l, r});
      1: q1.push_back({l, r});
      2: q2.push_back({l, r});
      default: q3.push_back({l, r});
    endcase
  endtask

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic qclr(input int i);
    case (i)
      0: q0.delete();
      1: q1.delete();
      2: q2.delete();
      default: q3.delete();
    endcase
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while (qsize(i) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (qsize(i) != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_u%0d: %0d pending, want 0", i, qsize(i));
      qclr(i);
    end
  endtask

  // pops one expectation after every tick step
  initial pend = '0;
  always @(negedge clk) begin
    if (pend[0] && q0.size() > 0)
      check("u0_lamps", 32'({8'(if0.la), 8'(if0.ra)}),
            32'(q0.pop_front()));
    if (pend[1] && q1.size() > 0)
      check("u1_lamps", 32'({8'(if1.la), 8'(if1.ra)}),
            32'(q1.pop_front()));
    if (pend[2] && q2.size() > 0)
      check("u2_lamps", 32'({8'(if2.la), 8'(if2.ra)}),
            32'(q2.pop_front()));
    if (pend[3] && q3.size() > 0)
      check("u3_lamps", 32'({8'(if3.la), 8'(if3.ra)}),
            32'(q3.pop_front()));
    pend[0] = if0.tick && !rst;
    pend[1] = if1.tick && !rst;
    pend[2] = if2.tick && !rst;
    pend[3] = if3.tick && !rst;
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    {if0.left, if0.right, if0.hazard} = '0;
    {if1.left, if1.right, if1.hazard} = '0;
    {if2.left, if2.right, if2.hazard} = '0;
    {if3.left, if3.right, if3.hazard} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_u0_la", 32'(if0.la), 32'h0);
    check("rst_u0_ra", 32'(if0.ra), 32'h0);
    check("rst_u0_busy", 32'(if0.busy), 32'h0);
    check("rst_u0_tick", 32'(if0.tick), 32'h0);
    check("rst_u3_tick", 32'(if3.tick), 32'h0);
    check("rst_u2_tick", 32'(if2.tick), 32'h1);
    @(posedge clk) #1 rst = 1'b0;

    fork
      begin : br_u0
        int n;
        n = 0;
        while (!if0.tick && n < 10) begin
          @(negedge clk);
          n++;
        end
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!if0.tick && n < 20);
        check("u0_tick_spacing", 32'(n), 32'd4);
        @(posedge clk) #1 if0.left = 1'b1;
        @(negedge clk) #1;
        push(0, 8'h01, 8'h00);
        push(0, 8'h03, 8'h00);
        push(0, 8'h07, 8'h00);
        push(0, 8'h00, 8'h00);
        push(0, 8'h01, 8'h00);
        drain(0);
        check("u0_busy_lseq", 32'(if0.busy), 32'h1);
        @(posedge clk) #1 if0.left = 1'b0;
        @(negedge clk) #1;
        push(0, 8'h03, 8'h00);
        push(0, 8'h07, 8'h00);
        push(0, 8'h00, 8'h00);
        push(0, 8'h00, 8'h00);
        drain(0);
        @(posedge clk) #1 if0.left = 1'b1;
        @(negedge clk) #1;
        push(0, 8'h01, 8'h00);
        push(0, 8'h03, 8'h00);
        drain(0);
        @(posedge clk) #1 if0.hazard = 1'b1;
        @(negedge clk) #1;
        push(0, 8'h07, 8'h07);
        push(0, 8'h00, 8'h00);
        push(0, 8'h07, 8'h07);
        push(0, 8'h00, 8'h00);
        drain(0);
        @(posedge clk) #1;
        if0.hazard = 1'b0;
        if0.left = 1'b0;
        @(negedge clk) #1;
        push(0, 8'h00, 8'h00);
        push(0, 8'h00, 8'h00);
        drain(0);
        check("u0_busy_idle", 32'(if0.busy), 32'h0);
      end
      begin : br_u1
        @(posedge clk) #1 if1.right = 1'b1;
        @(negedge clk) #1;
        push(1, 8'h00, 8'h01);
        push(1, 8'h00, 8'h02);
        push(1, 8'h00, 8'h04);
        push(1, 8'h00, 8'h00);
        push(1, 8'h00, 8'h01);
        drain(1);
        @(posedge clk) #1 if1.right = 1'b0;
      end
      begin : br_u2
        @(posedge clk) #1;
        if2.left = 1'b1;
        if2.right = 1'b1;
        @(negedge clk) #1;
        push(2, 8'h07, 8'h07);
        push(2, 8'h00, 8'h00);
        push(2, 8'h07, 8'h07);
        push(2, 8'h00, 8'h00);
        push(2, 8'h07, 8'h07);
        repeat (3) begin
          @(negedge clk);
          check("u2_tick_high", 32'(if2.tick), 32'h1);
        end
        drain(2);
        @(posedge clk) #1;
        if2.left = 1'b0;
        if2.right = 1'b0;
      end
    join

    begin : br_u3
      int n;
      @(posedge clk) #1 if3.left = 1'b1;
      @(negedge clk) #1;
      push(3, 8'h01, 8'h00);
      push(3, 8'h03, 8'h00);
      push(3, 8'h07, 8'h00);
      drain(3);
      @(posedge clk) #1 rst = 1'b1;
      @(posedge clk) #1 rst = 1'b0;
      check("u3_rst_la", 32'(if3.la), 32'h0);
      check("u3_rst_busy", 32'(if3.busy), 32'h0);
      check("u3_rst_tick", 32'(if3.tick), 32'h0);
      n = 0;
      @(negedge clk);
      while (!if3.tick && n < 20) begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end
      check("u3_rst_to_tick", 32'(n + 1), 32'd4);
      #1;
      push(3, 8'h01, 8'h00);
      push(3, 8'h03, 8'h00);
      drain(3);
      @(posedge clk) #1 if3.left = 1'b0;
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
